// File: rtl/fact_pkg.sv
// Shared constants and types for the memory-mapped factorial accelerator.
package fact_pkg;

  localparam logic [1:0] FACT_N      = 2'd0;
  localparam logic [1:0] FACT_GO     = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/fact_accel_if.sv
// Word-addressed system-bus port of the factorial accelerator.
interface fact_accel_if;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output a, output wd, input rd);
  modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/fact_core.sv
// Iterative factorial engine: one multiply per cycle, overflow judged on the full-width product.
module fact_core
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   p_q, p_d;
  logic [N_W-1:0]      c_q, c_d;
  logic [2*DATA_W-1:0] prod;
  logic                ovf;

  assign prod   = {{DATA_W{1'b0}}, p_q} * {{(2*DATA_W-N_W){1'b0}}, c_q};
  assign ovf    = |prod[2*DATA_W-1:DATA_W];
  assign result = p_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    case (state_q)
      RUN: begin
        if (c_q <= N_W'(1)) begin
          state_d = DONE;
        end else if (ovf) begin
          state_d = ERR;
          p_d     = '0;
        end else begin
          p_d = prod[DATA_W-1:0];
          c_d = c_q - N_W'(1);
        end
      end
      default: begin
        // A start while RUN is dropped; IDLE, DONE and ERR all accept one.
        if (start) begin
          state_d = RUN;
          p_d     = DATA_W'(1);
          c_d     = n;
        end
      end
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    err  = (state_q == ERR);
  end

endmodule

// File: rtl/fact_accel.sv
// Bus slave wrapper: operand register, GO decode and combinational read mux around fact_core.
module fact_accel
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  fact_accel_if.slave  bus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  logic [N_W-1:0]    n_q, n_d;
  logic [DATA_W-1:0] result;
  logic              go;
  logic              unused_wd;

  assign unused_wd = ^bus.wd[31:N_W];
  assign go        = bus.we && (bus.a == FACT_GO) && bus.wd[0];

  always_comb begin
    n_d = n_q;
    if (bus.we && (bus.a == FACT_N)) n_d = bus.wd[N_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) n_q <= '0;
    else      n_q <= n_d;
  end

  fact_core #(
    .DATA_W (DATA_W),
    .N_W    (N_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (go),
    .n      (n_q),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always_comb begin
    bus.rd = '0;
    case (bus.a)
      FACT_N:      bus.rd = 32'(n_q);
      FACT_GO:     bus.rd = {31'b0, busy};
      FACT_STATUS: bus.rd = {29'b0, busy, err, done};
      FACT_RESULT: bus.rd = 32'(result);
      default:     bus.rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Scoreboard bench for fact_accel at DATA_W=32 and DATA_W=16 against a plain-arithmetic factorial model.
module tb_fact_accel;
  import fact_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fact_accel_if bus32();
  fact_accel_if bus16();
  logic busy32, done32, err32;
  logic busy16, done16, err16;

  fact_accel #(.DATA_W(32), .N_W(5)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32), .busy(busy32), .done(done32), .err(err32)
  );
  fact_accel #(.DATA_W(16), .N_W(5)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .busy(busy16), .done(done16), .err(err16)
  );

  typedef struct {
    int              n;
    longint unsigned res;
    bit              err;
    int              lat;
    int              start;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: multiply n, n-1, ..., 2 in wide arithmetic and stop at the first result that no longer fits.
  function automatic exp_t model(int n, int dw);
    exp_t            e;
    longint unsigned p   = 1;
    longint unsigned lim = (64'd1 << dw) - 1;
    int              k   = 0;
    e.n     = n;
    e.err   = 1'b0;
    e.lat   = (n == 0) ? 1 : n;
    e.start = 0;
    for (int m = n; m >= 2; m--) begin
      k++;
      p = p * longint'(m);
      if (p > lim) begin
        e.err = 1'b1;
        e.lat = k;
        p     = 0;
        break;
      end
    end
    e.res = p;
    return e;
  endfunction

  task automatic drive(int sel, logic we, logic [1:0] a, logic [31:0] wd);
    if (sel == 32) begin
      bus32.we = we; bus32.a = a; bus32.wd = wd;
    end else begin
      bus16.we = we; bus16.a = a; bus16.wd = wd;
    end
  endtask

  function automatic logic [31:0] rd_of(int sel);
    return (sel == 32) ? bus32.rd : bus16.rd;
  endfunction

  function automatic logic busy_of(int sel);
    return (sel == 32) ? busy32 : busy16;
  endfunction

  function automatic logic [2:0] lv_of(int sel);
    return (sel == 32) ? {busy32, err32, done32} : {busy16, err16, done16};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the write edge with the bus parked on RESULT.
  task automatic bus_write(int sel, logic [1:0] a, logic [31:0] wd);
    drive(sel, 1'b1, a, wd);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, FACT_RESULT, 32'h0);
  endtask

  task automatic bus_read(int sel, logic [1:0] a, output logic [31:0] v);
    drive(sel, 1'b0, a, 32'h0);
    #1;
    v = rd_of(sel);
    drive(sel, 1'b0, FACT_RESULT, 32'h0);
  endtask

  task automatic start_job(int sel, int n, bit push);
    exp_t e;
    bus_write(sel, FACT_N, 32'(n) | ($urandom() & 32'hFFFF_FFE0));
    bus_write(sel, FACT_GO, 32'h1 | ($urandom() & 32'hFFFF_FFFE));
    check($sformatf("d%0d n=%0d busy_after_go", sel, n), 64'(busy_of(sel)), 64'd1);
    if (push) begin
      e       = model(n, sel);
      e.start = cyc;
      if (sel == 32) q32.push_back(e);
      else           q16.push_back(e);
    end
  endtask

  task automatic wait_idle(int sel);
    int i = 0;
    while (busy_of(sel) && i < 80) begin
      @(posedge clk);
      #1;
      i++;
    end
    check($sformatf("d%0d idle_within_budget", sel), 64'(busy_of(sel)), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(int sel, int n);
    exp_t        e;
    logic [31:0] v;
    e = model(n, sel);
    start_job(sel, n, 1'b1);
    wait_idle(sel);
    bus_read(sel, FACT_STATUS, v);
    check($sformatf("d%0d n=%0d status", sel, n), 64'(v), e.err ? 64'd2 : 64'd1);
    bus_read(sel, FACT_N, v);
    check($sformatf("d%0d n=%0d n_readback", sel, n), 64'(v), 64'(n));
  endtask

  // Monitor: a falling busy outside reset is a completion; pop and compare what the bus shows.
  task automatic complete(int sel);
    exp_t e;
    int   sz = (sel == 32) ? q32.size() : q16.size();
    check($sformatf("d%0d completion_expected", sel), 64'(sz > 0), 64'd1);
    if (sz == 0) return;
    e = (sel == 32) ? q32.pop_front() : q16.pop_front();
    check($sformatf("d%0d n=%0d result", sel, e.n), 64'(rd_of(sel)), e.res);
    check($sformatf("d%0d n=%0d latency", sel, e.n), 64'(cyc - e.start), 64'(e.lat));
    check($sformatf("d%0d n=%0d levels", sel, e.n), 64'(lv_of(sel)), e.err ? 64'b010 : 64'b001);
  endtask

  logic pb32, pb16;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      pb32 <= 1'b0;
      pb16 <= 1'b0;
    end else begin
      if (pb32 && !busy32) complete(32);
      if (pb16 && !busy16) complete(16);
      pb32 <= busy32;
      pb16 <= busy16;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    drive(32, 1'b0, FACT_N, 32'h0);
    drive(16, 1'b0, FACT_N, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 4; r++) begin
        bus_read((s == 0) ? 32 : 16, 2'(r), v);
        check($sformatf("d%0d reset_reg%0d", (s == 0) ? 32 : 16, r), 64'(v), 64'd0);
      end
      check($sformatf("d%0d reset_levels", (s == 0) ? 32 : 16), 64'(lv_of((s == 0) ? 32 : 16)), 64'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_job(32, 5);
    run_job(32, 12);
    run_job(32, 13);
    run_job(32, 0);
    run_job(32, 1);

    // GO at E0+2 is ignored; an N write at E0+3 is allowed and does not disturb the job.
    start_job(32, 5, 1'b1);
    @(posedge clk);
    #1;
    bus_write(32, FACT_GO, 32'h1);
    bus_write(32, FACT_N, 32'd7);
    wait_idle(32);
    bus_read(32, FACT_N, v);
    check("d32 n_written_while_busy", 64'(v), 64'd7);

    // GO landing on the completion edge E0+3 is ignored.
    start_job(32, 3, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus_write(32, FACT_GO, 32'h1);
    check("d32 go_on_completion_ignored", 64'(busy32), 64'd0);
    @(posedge clk);
    #1;
    check("d32 still_idle_after_go", 64'(lv_of(32)), 64'b001);

    run_job(16, 8);
    run_job(16, 9);

    // Reset at E0+4 of an n=10 job: everything returns to reset values at once.
    start_job(32, 10, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("d32 midrun_reset_levels", 64'(lv_of(32)), 64'd0);
    check("d32 midrun_reset_result", 64'(bus32.rd), 64'd0);
    bus_read(32, FACT_STATUS, v);
    check("d32 midrun_reset_status", 64'(v), 64'd0);
    bus_read(32, FACT_N, v);
    check("d32 midrun_reset_n", 64'(v), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_job(32, 3);

    repeat (24) begin
      int sel = ($urandom_range(0, 1) == 0) ? 32 : 16;
      run_job(sel, int'($urandom_range(0, 31)));
    end

    check("scoreboard_drained", 64'(q32.size() + q16.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
